phase_accumulator_nch: RTL

Multi-channel, parametrised successor to the 32-bit circular counter used in the sine wave generator. Each channel runs a modulo-2^ACC_WIDTH phase accumulator with its own increment (frequency word) and phase offset. Each channel outputs a truncated phase word that addresses the downstream sine LUT. Frequency updates can be immediate or deferred to the channel's next wrap, which keeps phase continuous. Channels are configured one at a time through a valid/ready port.

---
 rtl/phase_accumulator_nch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/phase_accumulator_nch.sv
`default_nettype none
// ============================================================================
// Module      : phase_accumulator_nch
// Description : NUM_CH independent modulo-2^ACC_WIDTH phase accumulators with
//               per-channel offset, deferred (wrap-aligned) frequency updates
//               and a truncated phase word per channel for a sine LUT.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_accumulator_nch #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 12,
    parameter int NUM_CH    = 4
) (
    input  logic                          CLK,
    input  logic                          SCLR,
    input  logic                          CE,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [3:0]                    cfg_ch,
    input  logic [ACC_WIDTH-1:0]          cfg_inc,
    input  logic [ACC_WIDTH-1:0]          cfg_offset,
    input  logic                          cfg_defer,
    input  logic                          cfg_sync,
    output logic [NUM_CH*OUT_WIDTH-1:0]   phase_out,
    output logic                          phase_valid,
    output logic [NUM_CH-1:0]             wrap
);

    localparam int c_phase_shift = ACC_WIDTH - OUT_WIDTH;

    logic [NUM_CH-1:0] w_pending;
    logic [15:0]       w_pending_ext;
    logic              w_xfer;

    // Unused channel slots read as not pending, so out-of-range indices are always accepted.
    assign w_pending_ext = 16'(w_pending);
    assign cfg_ready     = ~w_pending_ext[cfg_ch];
    assign w_xfer        = cfg_valid & cfg_ready;

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            phase_valid <= 1'b0;
        end else begin
            phase_valid <= CE;
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            localparam logic [3:0] c_ch_idx = 4'(c);

            logic [ACC_WIDTH-1:0] r_acc;
            logic [ACC_WIDTH-1:0] r_inc;
            logic [ACC_WIDTH-1:0] r_offset;
            logic [ACC_WIDTH-1:0] r_shadow_inc;
            logic                 r_pending;
            logic [OUT_WIDTH-1:0] r_phase;
            logic                 r_wrap;

            logic                 w_hit;
            logic [ACC_WIDTH:0]   w_sum;
            logic [ACC_WIDTH-1:0] w_acc_next;
            logic [ACC_WIDTH-1:0] w_inc_next;
            logic [ACC_WIDTH-1:0] w_offset_next;
            logic [ACC_WIDTH-1:0] w_shadow_next;
            logic                 w_pending_next;
            logic                 w_wrap_evt;
            logic [ACC_WIDTH-1:0] w_phase_full;

            assign w_hit = w_xfer & (cfg_ch == c_ch_idx);
            assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

            always_comb begin
                w_acc_next     = CE ? w_sum[ACC_WIDTH-1:0] : r_acc;
                w_wrap_evt     = CE & w_sum[ACC_WIDTH];
                w_inc_next     = r_inc;
                w_offset_next  = r_offset;
                w_shadow_next  = r_shadow_inc;
                w_pending_next = r_pending;

                if (w_hit) begin
                    w_offset_next = cfg_offset;
                    if (cfg_defer) begin
                        w_shadow_next = cfg_inc;
                    end
                    // A sync restart has no continuity to preserve, so a deferred
                    // increment is taken at once instead of waiting for a wrap.
                    if (!cfg_defer || cfg_sync) begin
                        w_inc_next = cfg_inc;
                    end else begin
                        w_pending_next = 1'b1;
                    end
                    if (cfg_sync) begin
                        w_acc_next = '0;
                        w_wrap_evt = 1'b0;
                    end
                end else if (r_pending && w_wrap_evt) begin
                    w_inc_next     = r_shadow_inc;
                    w_pending_next = 1'b0;
                end

                w_phase_full = w_acc_next + w_offset_next;
            end

            always_ff @(posedge CLK) begin
                if (SCLR) begin
                    r_acc        <= '0;
                    r_inc        <= '0;
                    r_offset     <= '0;
                    r_shadow_inc <= '0;
                    r_pending    <= 1'b0;
                    r_phase      <= '0;
                    r_wrap       <= 1'b0;
                end else begin
                    r_acc        <= w_acc_next;
                    r_inc        <= w_inc_next;
                    r_offset     <= w_offset_next;
                    r_shadow_inc <= w_shadow_next;
                    r_pending    <= w_pending_next;
                    r_phase      <= OUT_WIDTH'(w_phase_full >> c_phase_shift);
                    r_wrap       <= w_wrap_evt;
                end
            end

            assign w_pending[c]                        = r_pending;
            assign phase_out[c*OUT_WIDTH +: OUT_WIDTH] = r_phase;
            assign wrap[c]                             = r_wrap;
        end
    endgenerate

endmodule
`default_nettype wire
